// File: rtl/hidden_seq_pkg.sv
// hidden_seq_pkg
//   Shared definitions for the HiddenCPU issue sequencer and ALU:
//   sequencer state encoding, instruction width, instruction field
//   slices and opcode constants.
//   Instruction layout: {opcode[1:0], reg0Addr[1:0], reg1Addr[1:0]}.
package hidden_seq_pkg;

   localparam int unsigned INSTR_W = 6;

   localparam int unsigned OPC_MSB = 5;
   localparam int unsigned OPC_LSB = 4;
   localparam int unsigned RA_MSB  = 3;
   localparam int unsigned RA_LSB  = 2;
   localparam int unsigned RB_MSB  = 1;
   localparam int unsigned RB_LSB  = 0;

   localparam logic [1:0] OP_ADD    = 2'b00;
   localparam logic [1:0] OP_SUB    = 2'b01;
   localparam logic [1:0] OP_AND    = 2'b10;
   localparam logic [1:0] OP_BRANCH = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOAD    = 2'd1,
      ST_ISSUE   = 2'd2,
      ST_WAIT_BR = 2'd3
   } seq_state_e;

endpackage

// File: rtl/hidden_prog_mem.sv
// hidden_prog_mem
//   DEPTH x IW program buffer: one synchronous write port, one
//   combinational read port. Contents are not reset.
// Ports:
//   clk        in   clock
//   i_wr_en    in   write strobe
//   i_wr_addr  in   write index
//   i_wr_data  in   instruction to store
//   i_rd_addr  in   read index
//   o_rd_data  out  instruction at i_rd_addr (combinational)
module hidden_prog_mem #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned IW    = 6
) (
   input  logic                     clk,
   input  logic                     i_wr_en,
   input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
   input  logic [IW-1:0]            i_wr_data,
   input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
   output logic [IW-1:0]            o_rd_data
);

   logic [IW-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/hidden_issue_seq.sv
// hidden_issue_seq
//   Instruction issue sequencer in front of the HiddenCPU core. A program
//   is loaded over a valid/ready port into a small buffer and replayed one
//   instruction at a time; the core's branch feedback selects the next
//   program index. Out-of-range targets restart the program at index 0.
// Optional feature (macro HIDDEN_ISSUE_SEQ_RETIRE_CNT_EN):
//   adds retire_cnt[15:0], a saturating count of issue handshakes that
//   clears on each IDLE->ISSUE start.
// Ports:
//   clk            in   clock, all state on posedge
//   rst            in   asynchronous active-low reset
//   load_en        in   program load request (level)
//   load_valid     in   load beat valid
//   load_data      in   instruction to store
//   load_ready     out  buffer accepts beat (LOAD and not full)
//   start          in   IDLE->ISSUE when a program is loaded
//   stop           in   ISSUE/WAIT_BR->IDLE
//   issue_valid    out  issue_instr valid to core
//   issue_instr    out  instruction at pc
//   issue_ready    in   core accepts instruction
//   branch_taken   in   branch resolution, sampled in WAIT_BR
//   branch_offset  in   branch offset, added to pc mod DEPTH
//   pc             out  current program index
//   prog_len       out  number of loaded instructions
//   state          out  IDLE=0, LOAD=1, ISSUE=2, WAIT_BR=3
//   retire_cnt     out  handshake count (macro builds only)
module hidden_issue_seq
   import hidden_seq_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned IW    = INSTR_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load_en,
   input  logic                     load_valid,
   input  logic [IW-1:0]            load_data,
   output logic                     load_ready,
   input  logic                     start,
   input  logic                     stop,
   output logic                     issue_valid,
   output logic [IW-1:0]            issue_instr,
   input  logic                     issue_ready,
   input  logic                     branch_taken,
   input  logic [7:0]               branch_offset,
   output logic [$clog2(DEPTH)-1:0] pc,
   output logic [$clog2(DEPTH):0]   prog_len,
   output logic [1:0]               state
`ifdef HIDDEN_ISSUE_SEQ_RETIRE_CNT_EN
   ,
   output logic [15:0]              retire_cnt
`endif
);

   localparam int unsigned AW       = $clog2(DEPTH);
   localparam logic [AW:0] LEN_FULL = DEPTH[AW:0];
   localparam logic [AW:0] LEN_ONE  = {{AW{1'b0}}, 1'b1};

   seq_state_e    r_state, w_state_nxt;
   logic [AW-1:0] r_pc, w_pc_nxt, w_pc_br, w_br_tgt;
   logic [AW:0]   r_prog_len, w_len_nxt, w_pc_inc;
   logic          w_wr_en;
   logic          w_load_ready;
   logic          w_issue_hs;
   logic [IW-1:0] w_rd_data;
   logic [7-AW:0] w_unused_offset;

   // Only the low AW offset bits matter: the target wraps mod DEPTH.
   assign w_unused_offset = branch_offset[7:AW];

   assign w_load_ready = (r_state == ST_LOAD) && (r_prog_len < LEN_FULL);
   // stop in ISSUE pre-empts the handshake even with issue_ready high.
   assign w_issue_hs   = (r_state == ST_ISSUE) && issue_ready && !stop;

   assign w_pc_inc = {1'b0, r_pc} + LEN_ONE;
   assign w_br_tgt = r_pc + branch_offset[AW-1:0];

   always_comb begin
      if (branch_taken) begin
         w_pc_br = ({1'b0, w_br_tgt} < r_prog_len) ? w_br_tgt : '0;
      end else begin
         w_pc_br = (w_pc_inc >= r_prog_len) ? '0 : w_pc_inc[AW-1:0];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_len_nxt   = r_prog_len;
      w_wr_en     = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (load_en) begin
               w_state_nxt = ST_LOAD;
               w_len_nxt   = '0;
            end else if (start && (r_prog_len != '0)) begin
               w_state_nxt = ST_ISSUE;
               w_pc_nxt    = '0;
            end
         end
         ST_LOAD: begin
            if (load_valid && w_load_ready) begin
               w_wr_en   = 1'b1;
               w_len_nxt = r_prog_len + LEN_ONE;
            end
            if (!load_en) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (stop) begin
               w_state_nxt = ST_IDLE;
            end else if (issue_ready) begin
               w_state_nxt = ST_WAIT_BR;
            end
         end
         ST_WAIT_BR: begin
            w_pc_nxt    = w_pc_br;
            w_state_nxt = stop ? ST_IDLE : ST_ISSUE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_pc       <= '0;
         r_prog_len <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_prog_len <= w_len_nxt;
      end
   end

   hidden_prog_mem #(
      .DEPTH (DEPTH),
      .IW    (IW)
   ) u_prog_mem (
      .clk       (clk),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (r_prog_len[AW-1:0]),
      .i_wr_data (load_data),
      .i_rd_addr (r_pc),
      .o_rd_data (w_rd_data)
   );

`ifdef HIDDEN_ISSUE_SEQ_RETIRE_CNT_EN
   logic [15:0] r_retire_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_retire_cnt <= '0;
      end else if ((r_state == ST_IDLE) && (w_state_nxt == ST_ISSUE)) begin
         r_retire_cnt <= '0;
      end else if (w_issue_hs && (r_retire_cnt != '1)) begin
         r_retire_cnt <= r_retire_cnt + 16'd1;
      end
   end

   assign retire_cnt = r_retire_cnt;
`endif

   assign load_ready  = w_load_ready;
   assign issue_valid = (r_state == ST_ISSUE);
   assign issue_instr = w_rd_data;
   assign pc          = r_pc;
   assign prog_len    = r_prog_len;
   assign state       = r_state;

endmodule
